// File: rtl/bp_update_sched.sv
// gshare PHT update scheduler: buffers resolved branch outcomes, owns the GHR and
// arbitrates the single-port PHT between Fetch lookups and queued counter updates.
module bp_update_sched #(
    parameter int GBIT       = 10,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_res_valid,
    input  logic [GBIT-1:0]            i_res_idx,
    input  logic                       i_res_taken,
    output logic                       o_res_ready,
    input  logic                       i_lkp_valid,
    output logic                       o_lkp_grant,
    output logic                       o_fetch_stall,
    output logic                       o_pht_we,
    output logic [GBIT-1:0]            o_pht_waddr,
    output logic                       o_pht_wtaken,
    output logic [GBIT-1:0]            o_ghr,
    input  logic                       i_drain,
    output logic                       o_drain_done,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int SW = $clog2(STARVE_MAX+1);

    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [SW-1:0] STV_ZERO  = {SW{1'b0}};
    localparam logic [SW-1:0] STV_ONE   = SW'(1);
    localparam logic [SW-1:0] STV_MAX   = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [GBIT-1:0]   ghr_r;
    logic [GBIT-1:0]   idx_mem_r   [DEPTH];
    logic              taken_mem_r [DEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic [SW-1:0]     starve_r;

    logic              empty_s;
    logic              res_ready_s;
    logic              push_s;
    logic              pht_we_s;
    logic              grant_s;

    assign empty_s     = (count_r == CNT_ZERO);
    assign res_ready_s = (count_r != CNT_FULL) && (state_r == ST_RUN);
    assign push_s      = i_res_valid & res_ready_s;

    // PHT port arbitration: queued update vs Fetch lookup
    always_comb begin
        pht_we_s = 1'b0;
        grant_s  = 1'b0;
        if (!empty_s) begin
            if ((state_r == ST_DRAIN) || !i_lkp_valid || (starve_r == STV_MAX)) begin
                pht_we_s = 1'b1;
            end else begin
                grant_s = i_lkp_valid;
            end
        end else begin
            grant_s = i_lkp_valid;
        end
    end

    // Drain sequencing; emptiness is judged before this cycle's write
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (i_drain) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (empty_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE:  state_nxt_s = ST_RUN;
            default:  state_nxt_s = ST_RUN;
        endcase
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Global history shifts in the resolved direction at the MSB on every accepted push
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ghr_r <= {GBIT{1'b1}};
        end else if (push_s) begin
            ghr_r <= {i_res_taken, ghr_r[GBIT-1:1]};
        end
    end

    // Update FIFO storage and pointers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                idx_mem_r[i]   <= {GBIT{1'b0}};
                taken_mem_r[i] <= 1'b0;
            end
        end else begin
            if (push_s) begin
                idx_mem_r[wr_ptr_r]   <= i_res_idx;
                taken_mem_r[wr_ptr_r] <= i_res_taken;
                wr_ptr_r              <= wr_ptr_r + PTR_ONE;
            end
            if (pht_we_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Occupancy: simultaneous push and pop cancel
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_r <= CNT_ZERO;
        end else begin
            case ({push_s, pht_we_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Starvation counter: consecutive lookup wins while an update waits
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            starve_r <= STV_ZERO;
        end else if (empty_s || pht_we_s) begin
            starve_r <= STV_ZERO;
        end else if (grant_s && (starve_r != STV_MAX)) begin
            starve_r <= starve_r + STV_ONE;
        end else begin
            starve_r <= starve_r;
        end
    end

    assign o_res_ready   = res_ready_s;
    assign o_lkp_grant   = grant_s;
    assign o_fetch_stall = i_lkp_valid & ~grant_s;
    assign o_pht_we      = pht_we_s;
    assign o_pht_waddr   = empty_s ? {GBIT{1'b0}} : idx_mem_r[rd_ptr_r];
    assign o_pht_wtaken  = empty_s ? 1'b0 : taken_mem_r[rd_ptr_r];
    assign o_ghr         = ghr_r;
    assign o_drain_done  = (state_r == ST_DONE);
    assign o_count       = count_r;

endmodule

// File: tb/tb_bp_update_sched.sv
// Directed bench for bp_update_sched: reset, idle update, starvation, full FIFO,
// drain and reset during drain, with hand-computed expectations.
module tb_bp_update_sched;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_res_valid;
    logic [9:0]  i_res_idx;
    logic        i_res_taken;
    logic        o_res_ready;
    logic        i_lkp_valid;
    logic        o_lkp_grant;
    logic        o_fetch_stall;
    logic        o_pht_we;
    logic [9:0]  o_pht_waddr;
    logic        o_pht_wtaken;
    logic [9:0]  o_ghr;
    logic        i_drain;
    logic        o_drain_done;
    logic [2:0]  o_count;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [9:0]  exp_ghr;

    bp_update_sched #(.GBIT(10), .DEPTH(4), .STARVE_MAX(3)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_res_valid  (i_res_valid),
        .i_res_idx    (i_res_idx),
        .i_res_taken  (i_res_taken),
        .o_res_ready  (o_res_ready),
        .i_lkp_valid  (i_lkp_valid),
        .o_lkp_grant  (o_lkp_grant),
        .o_fetch_stall(o_fetch_stall),
        .o_pht_we     (o_pht_we),
        .o_pht_waddr  (o_pht_waddr),
        .o_pht_wtaken (o_pht_wtaken),
        .o_ghr        (o_ghr),
        .i_drain      (i_drain),
        .o_drain_done (o_drain_done),
        .o_count      (o_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic ghr_push(input logic taken);
        exp_ghr = {taken, exp_ghr[9:1]};
    endtask

    logic [3:0] fill_tk;
    logic [9:0] wa_exp [4];
    logic [3:0] wt_exp;

    initial begin
        fill_tk   = 4'b1101;
        wa_exp[0] = 10'h003; wa_exp[1] = 10'h004; wa_exp[2] = 10'h005; wa_exp[3] = 10'h006;
        wt_exp    = 4'b1011;

        i_rst = 1'b1; i_res_valid = 1'b0; i_res_idx = 10'h000; i_res_taken = 1'b0;
        i_lkp_valid = 1'b0; i_drain = 1'b0;
        exp_ghr = 10'h3FF;

        // Reset
        tick(); tick();
        i_rst = 1'b0;
        settle();
        chk_eq("rst_ghr", o_ghr, 10'h3FF);
        chk_eq("rst_count", o_count, 3'd0);
        chk_eq("rst_ready", o_res_ready, 1'b1);
        chk_eq("rst_we", o_pht_we, 1'b0);
        chk_eq("rst_done", o_drain_done, 1'b0);

        // Idle update
        i_res_valid = 1'b1; i_res_idx = 10'h155; i_res_taken = 1'b0;
        settle();
        chk_eq("idle_ready", o_res_ready, 1'b1);
        chk_eq("idle_we_pre", o_pht_we, 1'b0);
        tick(); ghr_push(1'b0);
        i_res_valid = 1'b0;
        settle();
        chk_eq("idle_we", o_pht_we, 1'b1);
        chk_eq("idle_waddr", o_pht_waddr, 10'h155);
        chk_eq("idle_wtaken", o_pht_wtaken, 1'b0);
        chk_eq("idle_ghr", o_ghr, 10'h1FF);
        chk_eq("idle_count1", o_count, 3'd1);
        tick(); settle();
        chk_eq("idle_count0", o_count, 3'd0);
        chk_eq("idle_we_post", o_pht_we, 1'b0);
        chk_eq("idle_waddr_empty", o_pht_waddr, 10'h000);

        // Starvation
        i_res_valid = 1'b1; i_res_idx = 10'h2AA; i_res_taken = 1'b1; i_lkp_valid = 1'b1;
        settle();
        chk_eq("stv_grant_push", o_lkp_grant, 1'b1);
        tick(); ghr_push(1'b1);
        i_res_valid = 1'b0;
        chk_eq("stv_ghr", exp_ghr, 10'h2FF);
        for (int k = 0; k < 3; k++) begin
            settle();
            chk_eq("stv_grant", o_lkp_grant, 1'b1);
            chk_eq("stv_we_defer", o_pht_we, 1'b0);
            tick();
        end
        settle();
        chk_eq("stv_force_we", o_pht_we, 1'b1);
        chk_eq("stv_force_stall", o_fetch_stall, 1'b1);
        chk_eq("stv_force_grant", o_lkp_grant, 1'b0);
        chk_eq("stv_force_waddr", o_pht_waddr, 10'h2AA);
        chk_eq("stv_force_wtaken", o_pht_wtaken, 1'b1);
        tick(); settle();
        chk_eq("stv_regrant", o_lkp_grant, 1'b1);
        chk_eq("stv_nostall", o_fetch_stall, 1'b0);
        chk_eq("stv_count", o_count, 3'd0);

        // Full FIFO with lookups held
        for (int k = 0; k < 4; k++) begin
            i_res_valid = 1'b1; i_res_idx = 10'(k + 1); i_res_taken = fill_tk[k];
            settle();
            chk_eq("full_fill_ready", o_res_ready, 1'b1);
            tick(); ghr_push(fill_tk[k]);
        end
        i_res_idx = 10'h005; i_res_taken = 1'b0;
        settle();
        chk_eq("full_count4", o_count, 3'd4);
        chk_eq("full_ready0", o_res_ready, 1'b0);
        chk_eq("full_force_we", o_pht_we, 1'b1);
        chk_eq("full_force_stall", o_fetch_stall, 1'b1);
        chk_eq("full_head_addr", o_pht_waddr, 10'h001);
        chk_eq("full_head_taken", o_pht_wtaken, 1'b1);
        tick(); settle();
        chk_eq("full_nopass_count", o_count, 3'd3);
        chk_eq("full_ready_again", o_res_ready, 1'b1);
        chk_eq("full_grant", o_lkp_grant, 1'b1);
        tick(); ghr_push(1'b0);
        i_lkp_valid = 1'b0; i_res_idx = 10'h006; i_res_taken = 1'b1;
        settle();
        chk_eq("full_drop_ready", o_res_ready, 1'b0);
        chk_eq("full_drop_we", o_pht_we, 1'b1);
        chk_eq("full_drop_addr", o_pht_waddr, 10'h002);
        chk_eq("full_drop_taken", o_pht_wtaken, 1'b0);
        tick();
        i_lkp_valid = 1'b1;
        settle();
        chk_eq("full_pop_only", o_count, 3'd3);
        chk_eq("full_next_ready", o_res_ready, 1'b1);
        tick(); ghr_push(1'b1);
        i_res_valid = 1'b0; i_lkp_valid = 1'b0;
        settle();
        chk_eq("full_refill", o_count, 3'd4);
        for (int k = 0; k < 4; k++) begin
            chk_eq("full_order_we", o_pht_we, 1'b1);
            chk_eq("full_order_addr", o_pht_waddr, wa_exp[k]);
            chk_eq("full_order_taken", o_pht_wtaken, wt_exp[k]);
            tick(); settle();
        end
        chk_eq("full_empty", o_count, 3'd0);
        chk_eq("full_ghr", o_ghr, exp_ghr);

        // Drain with lookups active
        i_lkp_valid = 1'b1;
        i_res_valid = 1'b1; i_res_idx = 10'h0A0; i_res_taken = 1'b1;
        tick(); ghr_push(1'b1);
        i_res_idx = 10'h0B0; i_res_taken = 1'b0;
        tick(); ghr_push(1'b0);
        i_res_valid = 1'b0; i_drain = 1'b1;
        settle();
        chk_eq("drn_pre_count", o_count, 3'd2);
        chk_eq("drn_pre_grant", o_lkp_grant, 1'b1);
        chk_eq("drn_pre_we", o_pht_we, 1'b0);
        tick();
        i_drain = 1'b0;
        settle();
        chk_eq("drn_w1_we", o_pht_we, 1'b1);
        chk_eq("drn_w1_stall", o_fetch_stall, 1'b1);
        chk_eq("drn_w1_addr", o_pht_waddr, 10'h0A0);
        chk_eq("drn_w1_ready", o_res_ready, 1'b0);
        tick(); settle();
        chk_eq("drn_w2_we", o_pht_we, 1'b1);
        chk_eq("drn_w2_stall", o_fetch_stall, 1'b1);
        chk_eq("drn_w2_addr", o_pht_waddr, 10'h0B0);
        chk_eq("drn_w2_done", o_drain_done, 1'b0);
        tick(); settle();
        chk_eq("drn_empty_we", o_pht_we, 1'b0);
        chk_eq("drn_empty_count", o_count, 3'd0);
        chk_eq("drn_empty_done", o_drain_done, 1'b0);
        tick(); settle();
        chk_eq("drn_done", o_drain_done, 1'b1);
        chk_eq("drn_done_ready", o_res_ready, 1'b0);
        chk_eq("drn_done_we", o_pht_we, 1'b0);
        tick(); settle();
        chk_eq("drn_run_done", o_drain_done, 1'b0);
        chk_eq("drn_run_ready", o_res_ready, 1'b1);
        chk_eq("drn_ghr", o_ghr, exp_ghr);

        // Reset in the middle of a drain
        i_res_valid = 1'b1; i_res_idx = 10'h0C0; i_res_taken = 1'b0;
        tick();
        i_res_idx = 10'h0D0; i_res_taken = 1'b1;
        tick();
        i_res_valid = 1'b0; i_drain = 1'b1;
        tick();
        i_drain = 1'b0;
        settle();
        chk_eq("rdr_first_we", o_pht_we, 1'b1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0; exp_ghr = 10'h3FF;
        settle();
        chk_eq("rdr_count", o_count, 3'd0);
        chk_eq("rdr_ghr", o_ghr, 10'h3FF);
        chk_eq("rdr_ready", o_res_ready, 1'b1);
        chk_eq("rdr_we", o_pht_we, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk_eq("rdr_no_done", o_drain_done, 1'b0);
            chk_eq("rdr_grant", o_lkp_grant, 1'b1);
            tick(); settle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
